// File: rtl/nova_alc_ctrl_pkg.sv
// NOVA ALC shared definitions: instruction field layout, field encodings,
// sequencer state encoding and small field-extraction helpers.
package nova_defs;

   // Instruction word is numbered [0:15], bit 0 is the MSB.
   localparam int ALC_BIT_CLASS  = 0;
   localparam int ALC_ACS_HI     = 1;
   localparam int ALC_ACS_LO     = 2;
   localparam int ALC_ACD_HI     = 3;
   localparam int ALC_ACD_LO     = 4;
   localparam int ALC_FUNC_HI    = 5;
   localparam int ALC_FUNC_LO    = 7;
   localparam int ALC_SHIFT_HI   = 8;
   localparam int ALC_SHIFT_LO   = 9;
   localparam int ALC_CARRY_HI   = 10;
   localparam int ALC_CARRY_LO   = 11;
   localparam int ALC_BIT_NOLOAD = 12;
   localparam int ALC_SKIP_HI    = 13;
   localparam int ALC_SKIP_LO    = 15;

   typedef enum logic [2:0] {
      ALC_FN_COM = 3'd0,
      ALC_FN_NEG = 3'd1,
      ALC_FN_MOV = 3'd2,
      ALC_FN_INC = 3'd3,
      ALC_FN_ADC = 3'd4,
      ALC_FN_SUB = 3'd5,
      ALC_FN_ADD = 3'd6,
      ALC_FN_AND = 3'd7
   } alc_func_e;

   typedef enum logic [1:0] {
      ALC_SH_NONE = 2'd0,
      ALC_SH_L    = 2'd1,
      ALC_SH_R    = 2'd2,
      ALC_SH_S    = 2'd3
   } alc_shift_e;

   typedef enum logic [1:0] {
      ALC_CY_KEEP = 2'd0,
      ALC_CY_Z    = 2'd1,
      ALC_CY_O    = 2'd2,
      ALC_CY_C    = 2'd3
   } alc_carry_e;

   typedef enum logic [2:0] {
      ALC_SK_NEVER = 3'd0,
      ALC_SK_SKP   = 3'd1,
      ALC_SK_SZC   = 3'd2,
      ALC_SK_SNC   = 3'd3,
      ALC_SK_SZR   = 3'd4,
      ALC_SK_SNR   = 3'd5,
      ALC_SK_SEZ   = 3'd6,
      ALC_SK_SBN   = 3'd7
   } alc_skip_e;

   typedef enum logic [1:0] {
      NOVA_ALC_IDLE = 2'd0,
      NOVA_ALC_READ = 2'd1,
      NOVA_ALC_EXEC = 2'd2,
      NOVA_ALC_WB   = 2'd3
   } alc_state_e;

   function automatic logic [1:0] alc_acs(input logic [0:15] w);
      return w[ALC_ACS_HI:ALC_ACS_LO];
   endfunction

   function automatic logic [1:0] alc_acd(input logic [0:15] w);
      return w[ALC_ACD_HI:ALC_ACD_LO];
   endfunction

   function automatic logic alc_noload(input logic [0:15] w);
      return w[ALC_BIT_NOLOAD];
   endfunction

   function automatic logic alc_is_alc(input logic [0:15] w);
      return w[ALC_BIT_CLASS];
   endfunction

endpackage

// File: rtl/nova_alc_ctrl.sv
// NOVA ALC instruction sequencer: IDLE -> READ -> EXEC -> WB.
// Reads ACS/ACD from the registered accumulator file, presents them to the
// external ALU, registers the ALU outputs and writes back in WB. Owns the
// architectural carry flag. Non-ALC words short-circuit READ -> WB as errors.
module nova_alc_ctrl
   import nova_defs::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             pclk,
   input  logic             prst,
   input  logic             ctl_start,
   input  logic [0:15]      ctl_inst,
   output logic             ctl_busy,
   output logic             ctl_done,
   output logic             ctl_skip,
   output logic             ctl_err,
   output logic [1:0]       rf_raddr_s,
   output logic [1:0]       rf_raddr_d,
   input  logic [0:WIDTH-1] rf_rdata_s,
   input  logic [0:WIDTH-1] rf_rdata_d,
   output logic             rf_we,
   output logic [1:0]       rf_waddr,
   output logic [0:WIDTH-1] rf_wdata,
   output logic [0:15]      alu_inst,
   output logic [0:WIDTH-1] alu_op1,
   output logic [0:WIDTH-1] alu_op2,
   output logic             alu_cin,
   input  logic [0:WIDTH-1] alu_result,
   input  logic             alu_cout,
   input  logic             alu_skip,
   output logic             carry
);

   alc_state_e       state_q, state_d;
   logic [0:15]      inst_q, inst_d;
   logic [0:WIDTH-1] res_q, res_d;
   logic             cout_q, cout_d;
   logic             skip_q, skip_d;
   logic             err_q, err_d;
   logic             carry_q, carry_d;
   logic             wb_write_s;

   // State and datapath registers; reset drops any in-flight instruction.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state_q <= NOVA_ALC_IDLE;
         inst_q  <= 16'h0000;
         res_q   <= '0;
         cout_q  <= 1'b0;
         skip_q  <= 1'b0;
         err_q   <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         res_q   <= res_d;
         cout_q  <= cout_d;
         skip_q  <= skip_d;
         err_q   <= err_d;
         carry_q <= carry_d;
      end
   end

   // Write-back qualifier: a loading, well-formed ALC instruction.
   assign wb_write_s = ~err_q & ~alc_noload(inst_q);

   // Next-state logic plus state-decoded outputs (no path from ctl_start).
   always_comb begin
      state_d    = state_q;
      inst_d     = inst_q;
      res_d      = res_q;
      cout_d     = cout_q;
      skip_d     = skip_q;
      err_d      = err_q;
      carry_d    = carry_q;

      ctl_busy   = 1'b1;
      ctl_done   = 1'b0;
      ctl_skip   = 1'b0;
      ctl_err    = 1'b0;
      rf_raddr_s = 2'd0;
      rf_raddr_d = 2'd0;
      rf_we      = 1'b0;
      rf_waddr   = 2'd0;
      rf_wdata   = '0;
      alu_inst   = 16'h0000;
      alu_op1    = '0;
      alu_op2    = '0;
      alu_cin    = 1'b0;
      carry      = carry_q;

      case (state_q)
         NOVA_ALC_IDLE: begin
            ctl_busy = 1'b0;
            if (ctl_start) begin
               inst_d  = ctl_inst;
               err_d   = 1'b0;
               state_d = NOVA_ALC_READ;
            end else begin
               state_d = NOVA_ALC_IDLE;
            end
         end
         NOVA_ALC_READ: begin
            rf_raddr_s = alc_acs(inst_q);
            rf_raddr_d = alc_acd(inst_q);
            if (!alc_is_alc(inst_q)) begin
               err_d   = 1'b1;
               state_d = NOVA_ALC_WB;
            end else begin
               state_d = NOVA_ALC_EXEC;
            end
         end
         NOVA_ALC_EXEC: begin
            // File data addressed in READ is valid now; hold the addresses
            // so the operands stay stable for the whole cycle.
            rf_raddr_s = alc_acs(inst_q);
            rf_raddr_d = alc_acd(inst_q);
            alu_inst   = inst_q;
            alu_op1    = rf_rdata_s;
            alu_op2    = rf_rdata_d;
            alu_cin    = carry_q;
            res_d      = alu_result;
            cout_d     = alu_cout;
            skip_d     = alu_skip;
            state_d    = NOVA_ALC_WB;
         end
         NOVA_ALC_WB: begin
            ctl_done = 1'b1;
            ctl_err  = err_q;
            ctl_skip = ~err_q & skip_q;
            if (wb_write_s) begin
               rf_we    = 1'b1;
               rf_waddr = alc_acd(inst_q);
               rf_wdata = res_q;
               carry_d  = cout_q;
            end else begin
               rf_we    = 1'b0;
            end
            state_d = NOVA_ALC_IDLE;
         end
         default: begin
            ctl_busy = 1'b0;
            state_d  = NOVA_ALC_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_nova_alc_ctrl.sv
// Self-checking bench for nova_alc_ctrl with a behavioural NOVA ALU and a
// registered 4-entry accumulator file. Expected completions are queued when
// an instruction is issued and popped when ctl_done is seen.
module tb_nova_alc_ctrl;

   typedef struct packed {
      logic        we;
      logic [1:0]  waddr;
      logic [15:0] wdata;
      logic        skip;
      logic        err;
   } exp_t;

   logic        pclk, prst, ctl_start;
   logic [15:0] ctl_inst;
   logic        ctl_busy, ctl_done, ctl_skip, ctl_err;
   logic [1:0]  rf_raddr_s, rf_raddr_d, rf_waddr;
   logic [15:0] rf_rdata_s, rf_rdata_d, rf_wdata;
   logic        rf_we;
   logic [15:0] alu_inst, alu_op1, alu_op2, alu_result;
   logic        alu_cin, alu_cout, alu_skip, carry;
   logic [17:0] alu_o;

   logic [15:0] fm [4];
   logic        tb_we;
   logic [1:0]  tb_waddr;
   logic [15:0] tb_wdata;

   logic [15:0] ref_ac [4];
   logic        ref_c;
   exp_t        sb_q [$];
   int          checks;
   int          failures;
   int          cyc;

   nova_alc_ctrl #(.WIDTH(16)) dut (
      .pclk(pclk), .prst(prst), .ctl_start(ctl_start), .ctl_inst(ctl_inst),
      .ctl_busy(ctl_busy), .ctl_done(ctl_done), .ctl_skip(ctl_skip), .ctl_err(ctl_err),
      .rf_raddr_s(rf_raddr_s), .rf_raddr_d(rf_raddr_d),
      .rf_rdata_s(rf_rdata_s), .rf_rdata_d(rf_rdata_d),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_inst(alu_inst), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout), .alu_skip(alu_skip),
      .carry(carry)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   // Behavioural NOVA ALU: returns {result[15:0], carry_out, skip}.
   function automatic logic [17:0] alu_fn(input logic [15:0] inst, input logic [15:0] s,
                                          input logic [15:0] d, input logic cin);
      logic        base, c, k, sk;
      logic [15:0] r;
      logic [16:0] sum;
      case (inst[5:4])
         2'b00:   base = cin;
         2'b01:   base = 1'b0;
         2'b10:   base = 1'b1;
         default: base = ~cin;
      endcase
      case (inst[10:8])
         3'd0:    sum = {1'b0, ~s};
         3'd1:    sum = {1'b0, ~s} + 17'd1;
         3'd2:    sum = {1'b0, s};
         3'd3:    sum = {1'b0, s} + 17'd1;
         3'd4:    sum = {1'b0, ~s} + {1'b0, d};
         3'd5:    sum = {1'b0, ~s} + {1'b0, d} + 17'd1;
         3'd6:    sum = {1'b0, s} + {1'b0, d};
         default: sum = {1'b0, s & d};
      endcase
      r = sum[15:0];
      c = base ^ sum[16];
      case (inst[7:6])
         2'b01:   begin k = r[15]; r = {r[14:0], c}; c = k; end
         2'b10:   begin k = r[0];  r = {c, r[15:1]}; c = k; end
         2'b11:   r = {r[7:0], r[15:8]};
         default: r = r;
      endcase
      case (inst[2:0])
         3'd0:    sk = 1'b0;
         3'd1:    sk = 1'b1;
         3'd2:    sk = (c == 1'b0);
         3'd3:    sk = (c != 1'b0);
         3'd4:    sk = (r == 16'h0000);
         3'd5:    sk = (r != 16'h0000);
         3'd6:    sk = (c == 1'b0) || (r == 16'h0000);
         default: sk = (c != 1'b0) && (r != 16'h0000);
      endcase
      return {r, c, sk};
   endfunction

   assign alu_o      = alu_fn(alu_inst, alu_op1, alu_op2, alu_cin);
   assign alu_result = alu_o[17:2];
   assign alu_cout   = alu_o[1];
   assign alu_skip   = alu_o[0];

   // Registered accumulator file with a bench preload port.
   always @(posedge pclk) begin
      if (tb_we) fm[tb_waddr] <= tb_wdata;
      else if (rf_we) fm[rf_waddr] <= rf_wdata;
      rf_rdata_s <= fm[rf_raddr_s];
      rf_rdata_d <= fm[rf_raddr_d];
   end

   function automatic logic [15:0] mk(input logic [1:0] acs, input logic [1:0] acd,
                                      input logic [2:0] fn, input logic [1:0] sh,
                                      input logic [1:0] cy, input logic nl,
                                      input logic [2:0] sk);
      return {1'b1, acs, acd, fn, sh, cy, nl, sk};
   endfunction

   // Advance to the next falling edge; retire a queued completion on ctl_done.
   task automatic step();
      exp_t e;
      @(negedge pclk);
      cyc++;
      if (ctl_done === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_done: ctl_done=1 at cycle %0d, no instruction expected", cyc);
         end else begin
            e = sb_q.pop_front();
            checks++;
            if (rf_we !== e.we) begin failures++; $display("FAIL sb_we: got %b want %b", rf_we, e.we); end
            checks++;
            if (ctl_err !== e.err) begin failures++; $display("FAIL sb_err: got %b want %b", ctl_err, e.err); end
            checks++;
            if (ctl_skip !== e.skip) begin failures++; $display("FAIL sb_skip: got %b want %b", ctl_skip, e.skip); end
            if (e.we) begin
               checks++;
               if (rf_waddr !== e.waddr) begin failures++; $display("FAIL sb_waddr: got %0d want %0d", rf_waddr, e.waddr); end
               checks++;
               if (rf_wdata !== e.wdata) begin failures++; $display("FAIL sb_wdata: got %h want %h", rf_wdata, e.wdata); end
            end
         end
      end
   endtask

   task automatic preload(input logic [1:0] a, input logic [15:0] v);
      tb_we = 1'b1; tb_waddr = a; tb_wdata = v;
      step();
      tb_we = 1'b0;
      ref_ac[a] = v;
   endtask

   task automatic push_exp(input logic [15:0] inst);
      exp_t        e;
      logic [17:0] o;
      e = '0;
      if (!inst[15]) begin
         e.err = 1'b1;
      end else begin
         o = alu_fn(inst, ref_ac[inst[14:13]], ref_ac[inst[12:11]], ref_c);
         e.we = ~inst[3]; e.waddr = inst[12:11]; e.wdata = o[17:2]; e.skip = o[0];
         if (!inst[3]) begin ref_ac[inst[12:11]] = o[17:2]; ref_c = o[1]; end
      end
      sb_q.push_back(e);
   endtask

   // Called at a falling edge with the DUT idle; returns at T0+1.
   task automatic issue(input logic [15:0] inst, input logic expect_done);
      if (expect_done) push_exp(inst);
      ctl_inst = inst; ctl_start = 1'b1;
      step();
      ctl_start = 1'b0;
   endtask

   task automatic test_reset();
      prst = 1'b1; ctl_start = 1'b0; ctl_inst = 16'h0000; tb_we = 1'b0;
      tb_waddr = 2'd0; tb_wdata = 16'h0000;
      step(); step();
      checks++; if (ctl_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", ctl_busy); end
      checks++; if (ctl_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", ctl_done); end
      checks++; if (carry !== 1'b0) begin failures++; $display("FAIL rst_carry: got %b want 0", carry); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we: got %b want 0", rf_we); end
      checks++; if ({ctl_skip, ctl_err} !== 2'b00) begin failures++; $display("FAIL rst_skip_err: got %b want 00", {ctl_skip, ctl_err}); end
      checks++; if (alu_inst !== 16'h0000) begin failures++; $display("FAIL rst_alu_inst: got %h want 0000", alu_inst); end
      prst = 1'b0;
      step();
      for (int i = 0; i < 4; i++) preload(i[1:0], 16'h0000);
      ref_c = 1'b0;
   endtask

   task automatic test_add();
      preload(2'd1, 16'h0003);
      preload(2'd2, 16'h0004);
      issue(mk(2'd1, 2'd2, 3'd6, 2'd0, 2'd0, 1'b0, 3'd0), 1'b1);
      checks++; if ({rf_raddr_s, rf_raddr_d} !== 4'b0110) begin failures++; $display("FAIL add_raddr: got %b want 0110", {rf_raddr_s, rf_raddr_d}); end
      checks++; if ({ctl_busy, ctl_done} !== 2'b10) begin failures++; $display("FAIL add_t1: busy/done got %b want 10", {ctl_busy, ctl_done}); end
      step();
      checks++; if (ctl_done !== 1'b0) begin failures++; $display("FAIL add_t2_done: got %b want 0", ctl_done); end
      checks++; if ({alu_op1, alu_op2} !== 32'h0003_0004) begin failures++; $display("FAIL add_ops: got %h want 00030004", {alu_op1, alu_op2}); end
      step();
      checks++; if ({ctl_done, rf_we, ctl_skip} !== 3'b110) begin failures++; $display("FAIL add_t3: done/we/skip got %b want 110", {ctl_done, rf_we, ctl_skip}); end
      checks++; if (rf_wdata !== 16'h0007) begin failures++; $display("FAIL add_wdata: got %h want 0007", rf_wdata); end
      step();
      checks++; if ({ctl_done, ctl_busy, carry} !== 3'b000) begin failures++; $display("FAIL add_t4: done/busy/carry got %b want 000", {ctl_done, ctl_busy, carry}); end
      checks++; if (fm[2] !== 16'h0007) begin failures++; $display("FAIL add_ac2: got %h want 0007", fm[2]); end
   endtask

   task automatic test_noload_szr();
      preload(2'd0, 16'hFFFF);
      issue(mk(2'd0, 2'd0, 3'd3, 2'd0, 2'd0, 1'b1, 3'd4), 1'b1);
      step(); step();
      checks++; if ({ctl_done, rf_we, ctl_skip} !== 3'b101) begin failures++; $display("FAIL nl_t3: done/we/skip got %b want 101", {ctl_done, rf_we, ctl_skip}); end
      step();
      checks++; if (fm[0] !== 16'hFFFF) begin failures++; $display("FAIL nl_ac0: got %h want ffff", fm[0]); end
      checks++; if (carry !== 1'b0) begin failures++; $display("FAIL nl_carry: got %b want 0", carry); end
   endtask

   task automatic test_carry();
      preload(2'd0, 16'h8000);
      preload(2'd1, 16'h8000);
      issue(mk(2'd0, 2'd1, 3'd6, 2'd0, 2'd0, 1'b0, 3'd0), 1'b1);
      step(); step();
      checks++; if ({rf_we, rf_wdata} !== 17'h1_0000) begin failures++; $display("FAIL cy_wb: we/wdata got %h want 10000", {rf_we, rf_wdata}); end
      checks++; if (carry !== 1'b0) begin failures++; $display("FAIL cy_t3_carry: got %b want 0", carry); end
      step();
      checks++; if (carry !== 1'b1) begin failures++; $display("FAIL cy_t4_carry: got %b want 1", carry); end
      preload(2'd3, 16'h1234);
      issue(mk(2'd3, 2'd2, 3'd2, 2'd0, 2'd0, 1'b0, 3'd0), 1'b1);
      step();
      checks++; if (alu_cin !== 1'b1) begin failures++; $display("FAIL cy_next_cin: got %b want 1", alu_cin); end
      step(); step();
      checks++; if (fm[2] !== 16'h1234) begin failures++; $display("FAIL mov_ac2: got %h want 1234", fm[2]); end
   endtask

   task automatic test_non_alc();
      issue(16'h2000, 1'b1);
      checks++; if (ctl_done !== 1'b0) begin failures++; $display("FAIL err_t1_done: got %b want 0", ctl_done); end
      step();
      checks++; if ({ctl_done, ctl_err, rf_we, ctl_skip} !== 4'b1100) begin failures++; $display("FAIL err_t2: done/err/we/skip got %b want 1100", {ctl_done, ctl_err, rf_we, ctl_skip}); end
      step();
      checks++; if ({ctl_busy, ctl_err, carry} !== 3'b001) begin failures++; $display("FAIL err_t3: busy/err/carry got %b want 001", {ctl_busy, ctl_err, carry}); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] seq [3];
      int          acc [3];
      int          n_acc, n_done;
      logic        prev_busy;
      seq[0] = mk(2'd1, 2'd1, 3'd3, 2'd0, 2'd0, 1'b0, 3'd0);
      seq[1] = mk(2'd1, 2'd1, 3'd3, 2'd0, 2'd1, 1'b0, 3'd0);
      seq[2] = mk(2'd2, 2'd1, 3'd6, 2'd1, 2'd0, 1'b0, 3'd5);
      for (int i = 0; i < 3; i++) push_exp(seq[i]);
      n_acc = 0; n_done = 0; prev_busy = ctl_busy;
      ctl_inst = seq[0]; ctl_start = 1'b1;
      for (int t = 0; t < 16; t++) begin
         step();
         if (ctl_done) n_done++;
         if (ctl_busy && !prev_busy) begin
            if (n_acc < 3) acc[n_acc] = cyc;
            n_acc++;
            if (n_acc < 3) ctl_inst = seq[n_acc];
            else ctl_start = 1'b0;
         end
         prev_busy = ctl_busy;
      end
      ctl_start = 1'b0;
      checks++; if (n_acc != 3) begin failures++; $display("FAIL b2b_accepts: got %0d want 3", n_acc); end
      checks++; if (n_done != 3) begin failures++; $display("FAIL b2b_dones: got %0d want 3", n_done); end
      if (n_acc >= 3) begin
         checks++; if (acc[1] - acc[0] != 4) begin failures++; $display("FAIL b2b_gap1: got %0d want 4", acc[1] - acc[0]); end
         checks++; if (acc[2] - acc[1] != 4) begin failures++; $display("FAIL b2b_gap2: got %0d want 4", acc[2] - acc[1]); end
      end
   endtask

   task automatic test_reset_exec();
      preload(2'd3, 16'h0005);
      issue(mk(2'd3, 2'd3, 3'd3, 2'd0, 2'd0, 1'b0, 3'd0), 1'b0);
      step();
      prst = 1'b1;
      #1;
      checks++; if ({ctl_busy, ctl_done, rf_we, carry} !== 4'b0000) begin failures++; $display("FAIL rx_async: busy/done/we/carry got %b want 0000", {ctl_busy, ctl_done, rf_we, carry}); end
      step();
      prst = 1'b0;
      ref_c = 1'b0;
      step(); step(); step();
      checks++; if (fm[3] !== 16'h0005) begin failures++; $display("FAIL rx_ac3_kept: got %h want 0005", fm[3]); end
      issue(mk(2'd3, 2'd3, 3'd3, 2'd0, 2'd0, 1'b0, 3'd0), 1'b1);
      step(); step(); step();
      checks++; if (fm[3] !== 16'h0006) begin failures++; $display("FAIL rx_ac3_next: got %h want 0006", fm[3]); end
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0; ref_c = 1'b0;
      test_reset();
      test_add();
      test_noload_szr();
      test_carry();
      test_non_alc();
      test_back_to_back();
      test_reset_exec();
      step(); step();
      checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_pending: got %0d outstanding want 0", sb_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (fm[i] !== ref_ac[i]) begin failures++; $display("FAIL final_ac%0d: got %h want %h", i, fm[i], ref_ac[i]); end
      end
      checks++; if (carry !== ref_c) begin failures++; $display("FAIL final_carry: got %b want %b", carry, ref_c); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
